// File: rtl/countdown_timer.sv
// Cascaded min:sec:cs countdown timer with IDLE/RUN/PAUSE/DONE control.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload last preset on expiry and keep running.
module countdown_timer #(
    parameter int CS_WIDTH  = 7,
    parameter int CS_MAX    = 99,
    parameter int SEC_WIDTH = 6,
    parameter int SEC_MAX   = 59,
    parameter int MIN_WIDTH = 7,
    parameter int MIN_MAX   = 99
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 load,
    input  logic [MIN_WIDTH-1:0] load_min,
    input  logic [SEC_WIDTH-1:0] load_sec,
    input  logic [CS_WIDTH-1:0]  load_cs,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 clear,
    output logic [MIN_WIDTH-1:0] min,
    output logic [SEC_WIDTH-1:0] sec,
    output logic [CS_WIDTH-1:0]  cs,
    output logic                 running,
    output logic                 expired,
    output logic                 done_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [CS_WIDTH-1:0]  CS_MAX_V  = CS_WIDTH'(CS_MAX);
    localparam logic [SEC_WIDTH-1:0] SEC_MAX_V = SEC_WIDTH'(SEC_MAX);
    localparam logic [MIN_WIDTH-1:0] MIN_MAX_V = MIN_WIDTH'(MIN_MAX);
    localparam logic [CS_WIDTH-1:0]  CS_ONE    = CS_WIDTH'(1);

    state_t               state_q, state_d;
    logic [MIN_WIDTH-1:0] min_q, min_d;
    logic [SEC_WIDTH-1:0] sec_q, sec_d;
    logic [CS_WIDTH-1:0]  cs_q, cs_d;
    logic                 done_q, done_d;

    logic [MIN_WIDTH-1:0] ld_min;
    logic [SEC_WIDTH-1:0] ld_sec;
    logic [CS_WIDTH-1:0]  ld_cs;
    logic                 cnt_zero;
    logic                 cnt_one;
    logic                 load_ok;

    assign ld_min   = (load_min > MIN_MAX_V) ? MIN_MAX_V : load_min;
    assign ld_sec   = (load_sec > SEC_MAX_V) ? SEC_MAX_V : load_sec;
    assign ld_cs    = (load_cs > CS_MAX_V) ? CS_MAX_V : load_cs;
    assign cnt_zero = (min_q == '0) && (sec_q == '0) && (cs_q == '0);
    assign cnt_one  = (min_q == '0) && (sec_q == '0) && (cs_q == CS_ONE);
    assign load_ok  = !clear && load && (state_q != S_RUN);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [MIN_WIDTH-1:0] pre_min_q;
    logic [SEC_WIDTH-1:0] pre_sec_q;
    logic [CS_WIDTH-1:0]  pre_cs_q;
    logic                 pre_zero;

    assign pre_zero = (pre_min_q == '0) && (pre_sec_q == '0) &&
                      (pre_cs_q == '0);

    // Shadow copy of the last accepted preset; clear leaves it intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_min_q <= '0;
            pre_sec_q <= '0;
            pre_cs_q  <= '0;
        end else if (load_ok) begin
            pre_min_q <= ld_min;
            pre_sec_q <= ld_sec;
            pre_cs_q  <= ld_cs;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            min_d   = '0;
            sec_d   = '0;
            cs_d    = '0;
        end else if (load_ok) begin
            state_d = S_IDLE;
            min_d   = ld_min;
            sec_d   = ld_sec;
            cs_d    = ld_cs;
        end else if (pause) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end
        end else if (start &&
                     (state_q == S_IDLE || state_q == S_PAUSE)) begin
            if (!cnt_zero) begin
                state_d = S_RUN;
            end
        end else if (tick && state_q == S_RUN && !cnt_zero) begin
            if (cnt_one) begin
                done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (!pre_zero) begin
                    min_d = pre_min_q;
                    sec_d = pre_sec_q;
                    cs_d  = pre_cs_q;
                end else begin
                    cs_d    = '0;
                    state_d = S_DONE;
                end
`else
                cs_d    = '0;
                state_d = S_DONE;
`endif
            end else if (cs_q != '0) begin
                cs_d = cs_q - 1'b1;
            end else begin
                // Borrow ripples cs -> sec -> min.
                cs_d = CS_MAX_V;
                if (sec_q != '0) begin
                    sec_d = sec_q - 1'b1;
                end else begin
                    sec_d = SEC_MAX_V;
                    min_d = min_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            cs_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
        end
    end

    assign min        = min_q;
    assign sec        = sec_q;
    assign cs         = cs_q;
    assign running    = (state_q == S_RUN);
    assign expired    = (state_q == S_DONE);
    assign done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus a randomized run
// checked against a total-centisecond reference model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic [6:0] load_cs = '0;
    logic [6:0] min;
    logic [5:0] sec;
    logic [6:0] cs;
    logic       running;
    logic       expired;
    logic       done_pulse;

    countdown_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .load       (load),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .load_cs    (load_cs),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .min        (min),
        .sec        (sec),
        .cs         (cs),
        .running    (running),
        .expired    (expired),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed = 0;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    // Reference model: the count as one total in centiseconds.
    int m_total = 0;
    int m_state = M_IDLE;
    int m_pulse = 0;
    int m_preset = 0;

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_total  = 0;
        m_state  = M_IDLE;
        m_pulse  = 0;
        m_preset = 0;
    endtask

    task automatic model_step();
        int p;
        p = 0;
        if (clear) begin
            m_total = 0;
            m_state = M_IDLE;
        end else if (load && m_state != M_RUN) begin
            m_total = sat(int'(load_min), 99) * 6000 +
                      sat(int'(load_sec), 59) * 100 +
                      sat(int'(load_cs), 99);
            m_preset = m_total;
            m_state  = M_IDLE;
        end else if (pause) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
        end else if (start && (m_state == M_IDLE || m_state == M_PAUSE)) begin
            if (m_total != 0) m_state = M_RUN;
        end else if (tick && m_state == M_RUN && m_total > 0) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
                p = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (m_preset != 0) m_total = m_preset;
                else m_state = M_DONE;
`else
                m_state = M_DONE;
`endif
            end
        end
        m_pulse = p;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_load(int mn, int s, int c);
        load_min = 7'(mn);
        load_sec = 6'(s);
        load_cs  = 7'(c);
        load     = 1'b1;
    endtask

    function automatic logic [22:0] obs();
        return {min, sec, cs, running, expired, done_pulse};
    endfunction

    function automatic logic [22:0] ev(int mn, int s, int c,
                                       bit r, bit e, bit p);
        return {7'(mn), 6'(s), 7'(c), r, e, p};
    endfunction

    function automatic logic [22:0] mexp();
        return {7'(m_total / 6000), 6'((m_total / 100) % 60),
                7'(m_total % 100), m_state == M_RUN,
                m_state == M_DONE, m_pulse != 0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if (obs() !== ev(0, 0, 0, 0, 0, 0)) begin
            failed++;
            $display("FAIL reset_init got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
        do_load(1, 0, 0);
        cyc();
        start = 1'b1;
        cyc();
        repeat (50) begin
            tick = 1'b1;
            cyc();
        end
        tests_run++;
        if (obs() !== ev(0, 59, 50, 1, 0, 0)) begin
            failed++;
            $display("FAIL reset_precount got %h want %h", obs(), ev(0, 59, 50, 1, 0, 0));
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (obs() !== ev(0, 0, 0, 0, 0, 0)) begin
            failed++;
            $display("FAIL reset_async got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_borrow_chain();
        clear = 1'b1;
        cyc();
        do_load(1, 0, 0);
        cyc();
        start = 1'b1;
        cyc();
        tick = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(0, 59, 99, 1, 0, 0)) begin
            failed++;
            $display("FAIL borrow_first got %h want %h", obs(), ev(0, 59, 99, 1, 0, 0));
        end
        repeat (5998) begin
            tick = 1'b1;
            cyc();
        end
        tests_run++;
        if (obs() !== ev(0, 0, 1, 1, 0, 0)) begin
            failed++;
            $display("FAIL borrow_one got %h want %h", obs(), ev(0, 0, 1, 1, 0, 0));
        end
        tick = 1'b1;
        cyc();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        tests_run++;
        if (obs() !== ev(1, 0, 0, 1, 0, 1)) begin
            failed++;
            $display("FAIL borrow_reload got %h want %h", obs(), ev(1, 0, 0, 1, 0, 1));
        end
`else
        tests_run++;
        if (obs() !== ev(0, 0, 0, 0, 1, 1)) begin
            failed++;
            $display("FAIL borrow_expire got %h want %h", obs(), ev(0, 0, 0, 0, 1, 1));
        end
        cyc();
        tests_run++;
        if (obs() !== ev(0, 0, 0, 0, 1, 0)) begin
            failed++;
            $display("FAIL borrow_pulse_end got %h want %h", obs(), ev(0, 0, 0, 0, 1, 0));
        end
        repeat (5) begin
            tick = 1'b1;
            cyc();
        end
        tests_run++;
        if (obs() !== ev(0, 0, 0, 0, 1, 0)) begin
            failed++;
            $display("FAIL borrow_no_underflow got %h want %h", obs(), ev(0, 0, 0, 0, 1, 0));
        end
`endif
    endtask

    task automatic test_pause_resume();
        clear = 1'b1;
        cyc();
        do_load(0, 2, 0);
        cyc();
        start = 1'b1;
        cyc();
        repeat (30) begin
            tick = 1'b1;
            cyc();
        end
        tests_run++;
        if (obs() !== ev(0, 1, 70, 1, 0, 0)) begin
            failed++;
            $display("FAIL pause_run got %h want %h", obs(), ev(0, 1, 70, 1, 0, 0));
        end
        pause = 1'b1;
        cyc();
        repeat (10) begin
            tick = 1'b1;
            cyc();
        end
        tests_run++;
        if (obs() !== ev(0, 1, 70, 0, 0, 0)) begin
            failed++;
            $display("FAIL pause_hold got %h want %h", obs(), ev(0, 1, 70, 0, 0, 0));
        end
        pause = 1'b1;
        start = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(0, 1, 70, 0, 0, 0)) begin
            failed++;
            $display("FAIL pause_wins got %h want %h", obs(), ev(0, 1, 70, 0, 0, 0));
        end
        start = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(0, 1, 70, 1, 0, 0)) begin
            failed++;
            $display("FAIL pause_resume got %h want %h", obs(), ev(0, 1, 70, 1, 0, 0));
        end
        repeat (170) begin
            tick = 1'b1;
            cyc();
        end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        tests_run++;
        if (obs() !== ev(0, 2, 0, 1, 0, 1)) begin
            failed++;
            $display("FAIL pause_reload got %h want %h", obs(), ev(0, 2, 0, 1, 0, 1));
        end
`else
        tests_run++;
        if (obs() !== ev(0, 0, 0, 0, 1, 1)) begin
            failed++;
            $display("FAIL pause_done got %h want %h", obs(), ev(0, 0, 0, 0, 1, 1));
        end
`endif
    endtask

    task automatic test_priority();
        clear = 1'b1;
        cyc();
        do_load(0, 0, 50);
        cyc();
        start = 1'b1;
        tick  = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(0, 0, 50, 1, 0, 0)) begin
            failed++;
            $display("FAIL prio_start_tick got %h want %h", obs(), ev(0, 0, 50, 1, 0, 0));
        end
        do_load(0, 30, 0);
        cyc();
        tests_run++;
        if (obs() !== ev(0, 0, 50, 1, 0, 0)) begin
            failed++;
            $display("FAIL prio_load_in_run got %h want %h", obs(), ev(0, 0, 50, 1, 0, 0));
        end
        clear = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(0, 0, 0, 0, 0, 0)) begin
            failed++;
            $display("FAIL prio_start_zero got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0));
        end
        do_load(0, 10, 0);
        clear = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(0, 0, 0, 0, 0, 0)) begin
            failed++;
            $display("FAIL prio_clear_load got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0));
        end
        do_load(0, 0, 20);
        cyc();
        pause = 1'b1;
        start = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(0, 0, 20, 0, 0, 0)) begin
            failed++;
            $display("FAIL prio_pause_start_idle got %h want %h", obs(), ev(0, 0, 20, 0, 0, 0));
        end
    endtask

    task automatic test_saturation();
        do_load(120, 63, 127);
        cyc();
        tests_run++;
        if (obs() !== ev(99, 59, 99, 0, 0, 0)) begin
            failed++;
            $display("FAIL sat_over got %h want %h", obs(), ev(99, 59, 99, 0, 0, 0));
        end
        do_load(98, 58, 98);
        cyc();
        tests_run++;
        if (obs() !== ev(98, 58, 98, 0, 0, 0)) begin
            failed++;
            $display("FAIL sat_under got %h want %h", obs(), ev(98, 58, 98, 0, 0, 0));
        end
        start = 1'b1;
        cyc();
        tick = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(98, 58, 97, 1, 0, 0)) begin
            failed++;
            $display("FAIL sat_count got %h want %h", obs(), ev(98, 58, 97, 1, 0, 0));
        end
    endtask

    task automatic test_random();
        clear = 1'b1;
        cyc();
        for (int i = 0; i < 4000; i++) begin
            tick  = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 31) == 0);
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) begin
                load_min = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
                load_sec = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 1));
                load_cs  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 30));
                load = 1'b1;
            end
            cyc();
            tests_run++;
            if (obs() !== mexp()) begin
                failed++;
                $display("FAIL random[%0d] got %h want %h", i, obs(), mexp());
            end
        end
    endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        clear = 1'b1;
        cyc();
        do_load(0, 0, 3);
        cyc();
        start = 1'b1;
        cyc();
        repeat (3) begin
            tick = 1'b1;
            cyc();
        end
        tests_run++;
        if (obs() !== ev(0, 0, 3, 1, 0, 1)) begin
            failed++;
            $display("FAIL reload_first got %h want %h", obs(), ev(0, 0, 3, 1, 0, 1));
        end
        repeat (2) begin
            tick = 1'b1;
            cyc();
        end
        tests_run++;
        if (obs() !== ev(0, 0, 1, 1, 0, 0)) begin
            failed++;
            $display("FAIL reload_mid got %h want %h", obs(), ev(0, 0, 1, 1, 0, 0));
        end
        tick = 1'b1;
        cyc();
        tests_run++;
        if (obs() !== ev(0, 0, 3, 1, 0, 1)) begin
            failed++;
            $display("FAIL reload_second got %h want %h", obs(), ev(0, 0, 3, 1, 0, 1));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_borrow_chain();
        test_pause_resume();
        test_priority();
        test_saturation();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
